cory_p2s_arb: RTL and testbench



---
 rtl/cory_p2s_arb.sv | 117 +++++++++++
 tb/tb_cory_p2s_arb.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cory_p2s_arb.sv
// Round-robin parallel-to-serial arbiter: M wide requesters share one N-bit beat channel.
// Optional CORY_P2S_ARB_LEN_EN adds a per-word last-beat index input i_a_n.
module cory_p2s_arb #(
  parameter int N  = 8,
  parameter int R  = 4,
  parameter int M  = 4,
  parameter int A  = N*R,
  parameter int BS = (R > 2) ? $clog2(R) : 1,
  parameter int MS = (M > 2) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [M-1:0]    i_a_v,
  input  logic [M*A-1:0]  i_a_d,
`ifdef CORY_P2S_ARB_LEN_EN
  input  logic [M*BS-1:0] i_a_n,
`endif
  output logic [M-1:0]    o_a_r,
  output logic            o_z_v,
  output logic [N-1:0]    o_z_d,
  output logic [BS-1:0]   o_z_s,
  output logic [MS-1:0]   o_z_id,
  output logic            o_z_l,
  input  logic            i_z_r
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state, w_state_nxt;
  logic [A-1:0]  r_hold;
  logic [BS-1:0] r_cnt;
  logic [MS-1:0] r_id;
  logic [MS-1:0] r_ptr;
  logic [BS-1:0] w_lastn;

`ifdef CORY_P2S_ARB_LEN_EN
  logic [BS-1:0] r_lastn;
  assign w_lastn = r_lastn;
`else
  assign w_lastn = BS'(R-1);
`endif

  logic          w_busy, w_last, w_beat, w_win, w_found, w_take;
  logic [MS-1:0] w_g, w_ptr_nxt;

  assign w_busy = (r_state == S_BUSY);
  assign w_last = w_busy & (r_cnt == w_lastn);
  assign w_beat = w_busy & i_z_r;
  // Regrant on the last-beat transfer keeps the channel bubble-free.
  assign w_win  = ~w_busy | (w_beat & w_last);

  always_comb begin
    w_found = 1'b0;
    w_g     = '0;
    for (int i = 0; i < M; i++) begin
      if (!w_found && i_a_v[(int'(r_ptr) + i) % M]) begin
        w_found = 1'b1;
        w_g     = MS'((int'(r_ptr) + i) % M);
      end
    end
  end

  assign w_take    = w_win & w_found;
  assign w_ptr_nxt = MS'((int'(w_g) + 1) % M);
  assign o_a_r     = w_take ? (M'(1) << w_g) : '0;

  assign o_z_v  = w_busy;
  assign o_z_d  = w_busy ? r_hold[int'(r_cnt)*N +: N] : '0;
  assign o_z_s  = r_cnt;
  assign o_z_id = r_id;
  assign o_z_l  = w_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_take) w_state_nxt = S_BUSY;
      S_BUSY: if (w_beat && w_last) w_state_nxt = w_take ? S_BUSY : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
`ifdef CORY_P2S_ARB_LEN_EN
      r_lastn <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_hold  <= i_a_d[int'(w_g)*A +: A];
        r_id    <= w_g;
        r_cnt   <= '0;
        r_ptr   <= w_ptr_nxt;
`ifdef CORY_P2S_ARB_LEN_EN
        r_lastn <= i_a_n[int'(w_g)*BS +: BS];
`endif
      end else if (w_beat) begin
        r_cnt <= w_last ? '0 : r_cnt + BS'(1);
      end
    end
  end

`ifdef SIM
  initial begin
    if (!(R == 2 || R == 4 || R == 8 || R == 16) || M < 1 || M > 8) begin
      $error("cory_p2s_arb: illegal parameters R=%0d M=%0d", R, M);
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_cory_p2s_arb.sv
// Directed bench for cory_p2s_arb (N=8, R=4, M=4): serialize, round-robin, stall, pointer wrap, reset.
module tb_cory_p2s_arb;
  localparam int N = 8, R = 4, M = 4, A = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   i_a_v;
  logic [127:0] i_a_d;
  logic [3:0]   o_a_r;
  logic         o_z_v;
  logic [7:0]   o_z_d;
  logic [1:0]   o_z_s;
  logic [1:0]   o_z_id;
  logic         o_z_l;
  logic         i_z_r;
`ifdef CORY_P2S_ARB_LEN_EN
  logic [7:0]   i_a_n;
`endif

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cory_p2s_arb #(.N(N), .R(R), .M(M)) dut (
    .clk(clk), .reset_n(reset_n), .i_a_v(i_a_v), .i_a_d(i_a_d),
`ifdef CORY_P2S_ARB_LEN_EN
    .i_a_n(i_a_n),
`endif
    .o_a_r(o_a_r), .o_z_v(o_z_v), .o_z_d(o_z_d), .o_z_s(o_z_s),
    .o_z_id(o_z_id), .o_z_l(o_z_l), .i_z_r(i_z_r)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input int s, input logic l,
                      input int id, input logic [3:0] ar);
    #1;
    chk({tag, "_v"},  32'(o_z_v),  1);
    chk({tag, "_d"},  32'(o_z_d),  32'(d));
    chk({tag, "_s"},  32'(o_z_s),  32'(s));
    chk({tag, "_l"},  32'(o_z_l),  32'(l));
    chk({tag, "_id"}, 32'(o_z_id), 32'(id));
    chk({tag, "_ar"}, 32'(o_a_r),  32'(ar));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_v"},  32'(o_z_v),  0);
    chk({tag, "_d"},  32'(o_z_d),  0);
    chk({tag, "_s"},  32'(o_z_s),  0);
    chk({tag, "_id"}, 32'(o_z_id), 0);
    chk({tag, "_l"},  32'(o_z_l),  0);
    chk({tag, "_ar"}, 32'(o_a_r),  0);
  endtask

  initial begin
    reset_n = 1'b0;
    i_a_v   = '0;
    i_a_d   = '0;
    i_z_r   = 1'b1;
`ifdef CORY_P2S_ARB_LEN_EN
    i_a_n   = 8'hff;
`endif
    #12;
    chk_reset("rst");
    reset_n = 1'b1;
    nxt;

    // Round-robin: all requesters valid, word k carries bytes 16k+3..16k
    for (int k = 0; k < 4; k++)
      i_a_d[k*32 +: 32] = {8'(16*k+3), 8'(16*k+2), 8'(16*k+1), 8'(16*k)};
    i_a_v = 4'hf;
    #1;
    chk("rr_gnt0", 32'(o_a_r), 32'h1);
    nxt;
    for (int b = 0; b < 20; b++) begin
      logic [3:0] ar;
      if (b == 19) i_a_v = 4'h0;
      ar = (b % 4 == 3 && b != 19) ? 4'(1 << ((b/4 + 1) % 4)) : 4'h0;
      beat($sformatf("rr%0d", b), 8'(16*((b/4)%4) + b%4), b%4, (b%4 == 3), (b/4)%4, ar);
      nxt;
    end
    #1;
    chk("rr_idle", 32'(o_z_v), 0);

    // Backpressure on requester 1 (pointer is 1), requester 0 waiting
    i_a_d[32 +: 32] = 32'h44332211;
    i_a_d[0  +: 32] = 32'h88776655;
    i_a_v = 4'b0010;
    #1;
    chk("bp_gnt", 32'(o_a_r), 32'h2);
    nxt;
    i_a_v = 4'b0001;
    beat("bp0", 8'h11, 0, 0, 1, 4'h0); nxt;
    i_z_r = 1'b0;
    for (int c = 0; c < 3; c++) begin
      beat($sformatf("bp_stall%0d", c), 8'h22, 1, 0, 1, 4'h0);
      nxt;
    end
    i_z_r = 1'b1;
    beat("bp1", 8'h22, 1, 0, 1, 4'h0); nxt;
    beat("bp2", 8'h33, 2, 0, 1, 4'h0); nxt;
    i_z_r = 1'b0;
    beat("bp3_stall", 8'h44, 3, 1, 1, 4'h0); nxt;
    i_z_r = 1'b1;
    beat("bp3", 8'h44, 3, 1, 1, 4'h1); nxt;

    // Pointer wrap: requester 0 granted from pointer 2, pointer now 1
    i_a_v = 4'h0;
    beat("sk0", 8'h55, 0, 0, 0, 4'h0); nxt;
    beat("sk1", 8'h66, 1, 0, 0, 4'h0); nxt;
    beat("sk2", 8'h77, 2, 0, 0, 4'h0); nxt;
    beat("sk3", 8'h88, 3, 1, 0, 4'h0); nxt;
    i_a_v = 4'b0011;
    #1;
    chk("sk_ptr", 32'(o_a_r), 32'h2);
    nxt;

    // Reset mid-word
    i_a_v = 4'h0;
    beat("rs0", 8'h11, 0, 0, 1, 4'h0); nxt;
    beat("rs1", 8'h22, 1, 0, 1, 4'h0);
    reset_n = 1'b0;
    #1;
    chk_reset("rs_async");
    nxt;
    reset_n = 1'b1;
    i_a_d[64 +: 32] = 32'hccbbaa99;
    i_a_v = 4'b0100;
    #1;
    chk("rs_gnt", 32'(o_a_r), 32'h4);
    nxt;
    i_a_v = 4'h0;
    beat("rs_new0", 8'h99, 0, 0, 2, 4'h0); nxt;
    beat("rs_new1", 8'haa, 1, 0, 2, 4'h0); nxt;
    beat("rs_new2", 8'hbb, 2, 0, 2, 4'h0); nxt;
    beat("rs_new3", 8'hcc, 3, 1, 2, 4'h0); nxt;
    #1;
    chk("rs_idle", 32'(o_z_v), 0);

`ifdef CORY_P2S_ARB_LEN_EN
    // Two-beat word from requester 3, requester 0 regranted on its last beat
    i_a_n[6 +: 2]   = 2'd1;
    i_a_d[96 +: 32] = 32'h00004433;
    i_a_v = 4'b1000;
    #1;
    chk("ln_gnt", 32'(o_a_r), 32'h8);
    nxt;
    i_a_v = 4'b1001;
    beat("ln0", 8'h33, 0, 0, 3, 4'h0); nxt;
    beat("ln1", 8'h44, 1, 1, 3, 4'h1); nxt;
    i_a_v = 4'h0;
    beat("ln_next", 8'h55, 0, 0, 0, 4'h0); nxt;
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
